truth_table_sequencer: RTL and testbench
========================================

// Module: truth_table_sequencer
// PURPOSE
//  Self-test controller for a small combinational unit (default: 3-input XNOR cell, inputs A,B,C, output f).
//  On start it drives all 2**N_IN input vectors in ascending order and holds each for DWELL cycles.
//  It samples f into a truth-table register, then compares the table against EXP_TABLE.
//  It reports pass, mismatch count and lowest failing vector. Sits between lab top-level and the cell under test.
// PARAMETERS
//  N_IN       3      number of cell inputs; vector width (1..4)
//  DWELL      4      cycles each vector is held; f sampled on last cycle (>=2)
//  EXP_TABLE  8'h69  expected table, width 2**N_IN; bit i = expected f for vector i (8'h69 = ~(A^B^C))
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           synchronous, active-high reset
//  start       in   1           begin sweep; sampled only in IDLE
//  abort       in   1           cancel sweep in progress
//  dut_f       in   1           cell output f
//  vec         out  N_IN        cell inputs; vec[N_IN-1]=A ... vec[0]=C
//  busy        out  1           high while sweeping (APPLY)
//  done        out  1           one-cycle pulse, sweep completed (not on abort)
//  pass        out  1           table==EXP_TABLE; valid from done, held until next start
//  table_out   out  2**N_IN     captured truth table
//  mism_cnt    out  N_IN+1      number of mismatching bits
//  fail_idx    out  N_IN        lowest mismatching vector index (0 if pass)
// BEHAVIOUR
//  Reset: state=IDLE; vec=0, busy=0, done=0, pass=0, table_out=0, mism_cnt=0, fail_idx=0; counters 0.
//  FSM: IDLE -> APPLY -> DONE -> IDLE.
//   IDLE:  start=1 at edge e0 -> APPLY. idx=0, cnt=0, vec=0, busy=1.
//          table_out, pass, mism_cnt and fail_idx clear to 0 at the same edge.
//   APPLY: vec=idx. cnt increments each cycle.
//          When cnt==DWELL-1: table_out[idx]<=dut_f at that edge.
//           If idx<2**N_IN-1: idx++, cnt=0 (stay in APPLY).
//           Else: -> DONE.
//   DONE:  one cycle. done=1, busy=0, vec=0.
//          pass, mism_cnt and fail_idx are registered at the DONE-entry edge, computed from the final table including the last sample.
//          Next edge -> IDLE, done=0.
//  Timing: vector i is driven from e0+i*DWELL to e0+(i+1)*DWELL.
//   done is high in the cycle after edge e0+2**N_IN*DWELL (DWELL=4, N_IN=3: edge e0+32).
//  start while busy or in DONE: ignored. No queuing.
//  abort in APPLY: -> IDLE next edge. busy=0, vec=0, no done pulse.
//   table_out keeps the partial capture. pass=0.
//   abort coinciding with the final sample edge: abort wins, no done.
//   abort in IDLE/DONE: no effect.
//  rst mid-sweep: full reset values at that edge. rst has priority over start and abort.
//  mism_cnt = popcount(table^EXP_TABLE). fail_idx = index of lowest set bit of (table^EXP_TABLE).
// STRUCTURE
//  Shared package lab_pkg: state encoding localparams (S_IDLE, S_APPLY, S_DONE) and default N_IN.
//  One natural sub-module: dwell_timer. Holds the cnt counter and flags last-cycle-of-dwell.
//   Parameter DWELL; ports clk, rst, clr, en, last.
//  Popcount and lowest-set-bit are combinational functions in this module.
// TESTING
//  1 Bench models cell as f=~(A^B^C). Pulse start -> vec steps 0..7, each for 4 cycles.
//    done at edge e0+32, table_out=8'h69, pass=1, mism_cnt=0.
//  2 Model with vector 5 inverted -> table_out=8'h49, pass=0, mism_cnt=1, fail_idx=5.
//  3 Model stuck-at-0 (f=0) -> table_out=8'h00, mism_cnt=4, fail_idx=0, pass=0.
//  4 abort during vector 3 -> busy=0 next cycle, vec=0, no done pulse.
//    table_out bits 0..2 captured, pass=0.
//  5 start re-pulsed mid-sweep -> ignored, sweep completes at original e0+32.
//    start during the DONE cycle -> ignored; busy stays 0.
//  6 rst asserted at cycle 10 of sweep -> all outputs at reset values next cycle.
//    A subsequent start runs a clean full sweep with pass=1.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared definitions for the truth-table self-test slice.
// State encodings and default cell width.
package lab_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_APPLY = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  localparam int N_IN_DEF = 3;

endpackage

// File: rtl/truth_table_sequencer_dwell_timer.sv
// Dwell counter for one input vector.
// last is high on the final cycle a vector is held.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(DWELL);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = en && (cnt_q == CW'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all input vectors of a small cell, captures f,
// and grades the captured table against EXP_TABLE.
module truth_table_sequencer
  import lab_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int DWELL = 4,
  parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 8'h69
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 dut_f,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [(1<<N_IN)-1:0] table_out,
  output logic [N_IN:0]        mism_cnt,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int TW = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_MAX = N_IN'(TW - 1);

  function automatic logic [N_IN:0] popcnt(
    input logic [TW-1:0] d
  );
    logic [N_IN:0] r;
    r = '0;
    for (int i = 0; i < TW; i++) begin
      r = r + {{N_IN{1'b0}}, d[i]};
    end
    return r;
  endfunction

  function automatic logic [N_IN-1:0] low_bit(
    input logic [TW-1:0] d
  );
    logic [N_IN-1:0] r;
    r = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (d[i]) r = N_IN'(i);
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [TW-1:0]   tbl_q, tbl_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   mism_q, mism_d;
  logic [N_IN-1:0] fail_q, fail_d;

  logic          tmr_en;
  logic          last;
  logic [TW-1:0] smp_tbl;
  logic [TW-1:0] diff;

  // abort masks the timer, so last never fires on an abort edge
  assign tmr_en = (state_q == S_APPLY) && !abort;

  dwell_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (!tmr_en),
    .en  (tmr_en),
    .last(last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_APPLY;
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last && idx_q == IDX_MAX) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    tbl_d   = tbl_q;
    pass_d  = pass_q;
    mism_d  = mism_q;
    fail_d  = fail_q;
    smp_tbl = tbl_q;
    if (last) smp_tbl[idx_q] = dut_f;
    diff = smp_tbl ^ EXP_TABLE;
    if (state_q == S_IDLE && start) begin
      idx_d  = '0;
      tbl_d  = '0;
      pass_d = 1'b0;
      mism_d = '0;
      fail_d = '0;
    end else if (state_q == S_APPLY) begin
      if (abort) begin
        pass_d = 1'b0;
      end else if (last) begin
        tbl_d = smp_tbl;
        if (idx_q == IDX_MAX) begin
          pass_d = (diff == '0);
          mism_d = popcnt(diff);
          fail_d = low_bit(diff);
        end else begin
          idx_d = idx_q + N_IN'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tbl_q   <= '0;
      pass_q  <= 1'b0;
      mism_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      pass_q  <= pass_d;
      mism_q  <= mism_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    vec       = (state_q == S_APPLY) ? idx_q : '0;
    busy      = (state_q == S_APPLY);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    table_out = tbl_q;
    mism_cnt  = mism_q;
    fail_idx  = fail_q;
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer with a behavioural XNOR3
// cell model and selectable faults.
module tb_truth_table_sequencer;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort, dut_f, f_good;
  logic [2:0] vec;
  logic       busy, done, pass;
  logic [7:0] table_out;
  logic [3:0] mism_cnt;
  logic [2:0] fail_idx;
  int         mode;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         mode;
    logic [7:0] tbl;
    logic       ps;
    int         mism;
    int         fidx;
  } vec_t;

  vec_t tv[3];
  vec_t sb[$];

  truth_table_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .dut_f    (dut_f),
    .vec      (vec),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .table_out(table_out),
    .mism_cnt (mism_cnt),
    .fail_idx (fail_idx)
  );

  always #5 clk = ~clk;

  // 0: good cell, 1: vector 5 inverted, 2: stuck-at-0
  always_comb begin
    f_good = ~(vec[2] ^ vec[1] ^ vec[0]);
    dut_f  = f_good;
    if (mode == 1 && vec == 3'd5) dut_f = ~f_good;
    if (mode == 2) dut_f = 1'b0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_sweep(input bit repulse, input bit st_done,
                           input vec_t v);
    int   verr;
    bit   got;
    vec_t e;
    sb.push_back(v);
    verr = 0;
    got = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (k > 0) @(negedge clk);
      start = repulse && (k == 5 || k == 20);
      if (done) begin
        got = 1;
        chk("done_edge", k, 32);
        chk("busy_in_done", busy, 0);
        chk("vec_in_done", vec, 0);
        e = sb.pop_front();
        chk("table_out", table_out, e.tbl);
        chk("pass", pass, e.ps);
        chk("mism_cnt", mism_cnt, e.mism);
        chk("fail_idx", fail_idx, e.fidx);
        if (st_done) start = 1'b1;
      end else if (vec !== 3'(k / DWELL) || busy !== 1'b1) begin
        verr++;
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      void'(sb.pop_front());
    end
    chk("vec_seq", verr, 0);
    @(negedge clk) start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    chk("pass_held", pass, v.ps);
    chk("table_held", table_out, v.tbl);
    @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int dn;
    tv[0] = '{mode: 0, tbl: 8'h69, ps: 1'b1, mism: 0, fidx: 0};
    tv[1] = '{mode: 1, tbl: 8'h49, ps: 1'b0, mism: 1, fidx: 5};
    tv[2] = '{mode: 2, tbl: 8'h00, ps: 1'b0, mism: 4, fidx: 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", vec, 0);
    chk("rst_pass", pass, 0);
    chk("rst_table", table_out, 0);
    chk("rst_mism", mism_cnt, 0);
    chk("rst_fidx", fail_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      mode = tv[i].mode;
      run_sweep(1'b0, 1'b0, tv[i]);
    end

    // abort while vector 3 is applied
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_abort_vec", vec, 3);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_vec", vec, 0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("abort_no_done", dn, 0);
    chk("abort_table", table_out, 8'h01);
    chk("abort_pass", pass, 0);

    // start re-pulsed mid-sweep and during DONE
    run_sweep(1'b1, 1'b1, tv[0]);

    // reset mid-sweep, then a clean sweep
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_vec", vec, 0);
    chk("mrst_done", done, 0);
    chk("mrst_table", table_out, 0);
    chk("mrst_pass", pass, 0);
    chk("mrst_mism", mism_cnt, 0);
    chk("mrst_fidx", fail_idx, 0);
    @(negedge clk);
    run_sweep(1'b0, 1'b0, tv[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
